// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: replays a software-loaded table of 56-bit I2C command words into the
// i2cMaster_withFIFO command FIFO and tracks in-order completions. Optional auto re-run: I2C_SEQ_AUTO_REPEAT_EN.
// state | meaning
// IDLE  | waiting for seq_start
// ISSUE | pushing table entries into the master FIFO
// WAIT  | every entry issued, collecting completions
// GAP   | delay before an automatic re-run (I2C_SEQ_AUTO_REPEAT_EN only)
module i2c_cmd_sequencer #(
  parameter int TABLE_ADDR_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES    = 1_000_000,
  parameter int REPEAT_GAP_CYCLES = 100_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_wr_en,
  input  logic [TABLE_ADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [55:0]                 cfg_wr_data,
  input  logic [TABLE_ADDR_WIDTH:0]   seq_len,
  input  logic                        seq_start,
  input  logic                        seq_repeat,
  output logic                        seq_busy,
  output logic                        seq_done,
  output logic                        seq_timeout,
  output logic [55:0]                 i2c_fifo_din,
  output logic                        i2c_fifo_wr_en,
  input  logic                        i2c_fifo_full,
  input  logic                        i2c_wr_data_success,
  input  logic                        i2c_rdata_valid,
  input  logic [7:0]                  i2c_rdata,
  output logic [7:0]                  rd_data,
  output logic [TABLE_ADDR_WIDTH-1:0] rd_index,
  output logic                        rd_valid
);

  localparam int AW      = TABLE_ADDR_WIDTH;
  localparam int PW      = AW + 1;
  localparam int DEPTH_I = 1 << AW;
  localparam logic [PW-1:0] DEPTH = PW'(DEPTH_I);
  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
`ifdef I2C_SEQ_AUTO_REPEAT_EN
  localparam logic [1:0] S_GAP   = 2'd3;
  localparam int GW = (REPEAT_GAP_CYCLES < 1) ? 1 : $clog2(REPEAT_GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(REPEAT_GAP_CYCLES);
  logic [GW-1:0] gap_cnt;
`else
  logic unused_repeat;
  assign unused_repeat = seq_repeat ^ (REPEAT_GAP_CYCLES < 0);
`endif

  logic [1:0]    state;
  logic [PW-1:0] len;
  logic [PW-1:0] issue_ptr;
  logic [PW-1:0] cmpl_ptr;
  logic [PW-1:0] cmpl_next;
  logic [PW-1:0] start_len;
  logic [TW-1:0] to_cnt;
  logic          in_run;
  logic          outstanding;
  logic          cmpl_evt;
  logic          rd_evt;
  logic          issue_acc;
  logic          to_run;
  logic          to_hit;

  logic [55:0] cmd_table [DEPTH_I];

  // Distributed table: no reset, frozen while a sequence owns it.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && !seq_busy) cmd_table[cfg_wr_addr] <= cfg_wr_data;
  end

  assign seq_busy       = (state != S_IDLE);
  assign in_run         = (state == S_ISSUE) || (state == S_WAIT);
  assign outstanding    = (cmpl_ptr < issue_ptr);
  assign cmpl_evt       = in_run && outstanding && (i2c_wr_data_success || i2c_rdata_valid);
  assign rd_evt         = in_run && outstanding && i2c_rdata_valid;
  assign cmpl_next      = cmpl_ptr + PW'(cmpl_evt);
  assign issue_acc      = (state == S_ISSUE) && !i2c_fifo_full;
  assign i2c_fifo_wr_en = issue_acc;
  assign i2c_fifo_din   = (state == S_ISSUE) ? cmd_table[issue_ptr[AW-1:0]] : '0;
  assign start_len      = (seq_len > DEPTH) ? DEPTH : seq_len;

  // The watchdog only runs while the master owes us something or we are stuck behind full.
  assign to_run = in_run && (outstanding || ((state == S_ISSUE) && i2c_fifo_full));
  assign to_hit = to_run && !cmpl_evt && (to_cnt <= TW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      len         <= '0;
      issue_ptr   <= '0;
      cmpl_ptr    <= '0;
      to_cnt      <= '0;
      seq_done    <= 1'b0;
      seq_timeout <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_index    <= '0;
`ifdef I2C_SEQ_AUTO_REPEAT_EN
      gap_cnt     <= '0;
`endif
    end else begin
      seq_done    <= 1'b0;
      seq_timeout <= 1'b0;
      rd_valid    <= rd_evt;
      if (rd_evt) begin
        rd_data  <= i2c_rdata;
        rd_index <= cmpl_ptr[AW-1:0];
      end
      if (cmpl_evt) begin
        cmpl_ptr <= cmpl_next;
        to_cnt   <= TO_LOAD;
      end else if (to_run && (to_cnt != '0)) begin
        to_cnt <= to_cnt - TW'(1);
      end

      case (state)
        S_IDLE: begin
          if (seq_start) begin
            len       <= start_len;
            issue_ptr <= '0;
            cmpl_ptr  <= '0;
            to_cnt    <= TO_LOAD;
            if (start_len == '0) seq_done <= 1'b1;
            else                 state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (to_hit) begin
            seq_timeout <= 1'b1;
            state       <= S_IDLE;
          end else if (issue_acc) begin
            issue_ptr <= issue_ptr + PW'(1);
            if ((issue_ptr + PW'(1)) == len) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cmpl_evt && (cmpl_next == len)) begin
            seq_done <= 1'b1;
`ifdef I2C_SEQ_AUTO_REPEAT_EN
            if (seq_repeat) begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end else if (to_hit) begin
            seq_timeout <= 1'b1;
            state       <= S_IDLE;
          end
        end
`ifdef I2C_SEQ_AUTO_REPEAT_EN
        S_GAP: begin
          // seq_repeat is re-checked at expiry so software can cancel during the gap.
          if (gap_cnt <= GW'(1)) begin
            if (seq_repeat) begin
              state     <= S_ISSUE;
              issue_ptr <= '0;
              cmpl_ptr  <= '0;
              to_cnt    <= TO_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/i2c_cmd_sequencer.md
# i2c_cmd_sequencer

Upstream command source for the `i2cMaster_withFIFO` I2C master. It holds a software-loaded table of 56-bit I2C transaction words and pushes them into the master's command FIFO under `i2c_fifo_full` back-pressure. It tracks in-order completions reported by the master, tags each read result with its table index, and signals sequence done or timeout. It replaces ad-hoc free-running command counters in board top levels.

## Interface
Parameters:
- `TABLE_ADDR_WIDTH`, default 4: table depth is 2^TABLE_ADDR_WIDTH entries.
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles with work outstanding before a timeout is declared.
- `REPEAT_GAP_CYCLES`, default 100_000: gap between repeated runs. Used only with `I2C_SEQ_AUTO_REPEAT_EN`.

Ports:
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_wr_en`  in  1  table write strobe.
- `cfg_wr_addr`  in  TABLE_ADDR_WIDTH  table write index.
- `cfg_wr_data`  in  56  entry, in master word format {dev_addr[6:0], rw, data_addr[15:0], wdata[7:0], ctrl_byte[7:0], clk_div[15:0]}; rw=1 means read.
- `seq_len`  in  TABLE_ADDR_WIDTH+1  number of entries to run; sampled on start.
- `seq_start`  in  1  start pulse.
- `seq_repeat`  in  1  request automatic re-run; sampled at end of each run.
- `seq_busy`  out  1  sequence in progress.
- `seq_done`  out  1  one-cycle pulse: every entry completed.
- `seq_timeout`  out  1  one-cycle pulse: run aborted on timeout.
- `i2c_fifo_din`  out  56  word to the master FIFO.
- `i2c_fifo_wr_en`  out  1  FIFO write strobe.
- `i2c_fifo_full`  in  1  FIFO full.
- `i2c_wr_data_success`  in  1  write-completion pulse from the master.
- `i2c_rdata_valid`  in  1  read-completion pulse from the master.
- `i2c_rdata`  in  8  read byte.
- `rd_data`  out  8  captured read byte.
- `rd_index`  out  TABLE_ADDR_WIDTH  table index of the captured read.
- `rd_valid`  out  1  one-cycle pulse qualifying `rd_data`/`rd_index`.

## Operation
- Table: distributed memory with asynchronous read and no reset.
  - `cfg_wr_en` writes on the clk edge when `seq_busy`=0.
  - Writes are ignored while busy.
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE, on `seq_start`:
  - Latch len = min(`seq_len`, 2^TABLE_ADDR_WIDTH).
  - Clear `issue_ptr`, `cmpl_ptr` and the timeout counter.
  - If len=0: pulse `seq_done` next cycle and stay IDLE.
  - Otherwise go to ISSUE.
- ISSUE:
  - `i2c_fifo_wr_en` = ~`i2c_fifo_full`, combinationally; `i2c_fifo_din` = table[`issue_ptr`].
  - `issue_ptr` increments on each accepted write.
  - After entry len-1 is accepted, go to WAIT.
- Completion: a cycle with `i2c_wr_data_success` | `i2c_rdata_valid` while `cmpl_ptr` < `issue_ptr`.
  - Counted in both ISSUE and WAIT.
  - Increments `cmpl_ptr`; coincident pulses count once.
  - Completions with nothing outstanding, or while in IDLE/GAP, are ignored.
- Read capture: a counted `i2c_rdata_valid` registers `rd_data`=`i2c_rdata` and `rd_index`=`cmpl_ptr` (pre-increment), and pulses `rd_valid` next cycle.
- WAIT: when `cmpl_ptr`=len, pulse `seq_done`, then go to GAP (macro on and `seq_repeat`=1) or IDLE.
- Timeout:
  - Counter runs in ISSUE/WAIT while `cmpl_ptr` < `issue_ptr`, or while stalled on full.
  - It clears on each completion.
  - At TIMEOUT_CYCLES: pulse `seq_timeout`, go to IDLE.
  - Commands already in the FIFO are not recalled.
- `seq_start` while busy is ignored.

## Timing
- Reset values:
  - State IDLE; `seq_busy`, `seq_done`, `seq_timeout`, `i2c_fifo_wr_en`, `rd_valid` = 0.
  - `rd_data`, `rd_index` = 0.
  - `i2c_fifo_din` = 0 (forced to 0 outside ISSUE).
- `seq_start` at edge N: `seq_busy`=1 and first possible `i2c_fifo_wr_en` in cycle N+1.
- Issue throughput: at most one FIFO write per cycle. Back-pressure is zero-latency: no write in any cycle where full=1.
- Read capture latency: `rd_valid` asserts one cycle after `i2c_rdata_valid`.
- `seq_done` asserts the cycle after the final completion; `seq_busy` falls in the same cycle.
- Reset mid-run aborts immediately with no pulses.

## Configuration
- `I2C_SEQ_AUTO_REPEAT_EN` defined:
  - After `seq_done` with `seq_repeat`=1, the block enters GAP.
  - GAP counts REPEAT_GAP_CYCLES with `seq_busy`=1, then re-enters ISSUE with the latched len.
  - Deasserting `seq_repeat` during GAP ends the run to IDLE at gap expiry.
- Undefined: GAP state is absent and `seq_repeat` is ignored; every run is one-shot.

## Test plan
- Load 4 entries (2 writes data 0xAB/0xAC, 2 reads), `seq_len`=4, start; model acks in order with read bytes 0x11/0x22 -> exactly 4 FIFO writes in table order; `rd_valid` twice with (0x11, idx 2) and (0x22, idx 3); one `seq_done`.
- Hold `i2c_fifo_full`=1 for 20 cycles mid-issue -> no `i2c_fifo_wr_en` during hold; remaining entries follow on release; no entry duplicated or skipped.
- `seq_len`=0 -> `seq_done` pulse 1 cycle after start, zero FIFO writes; `seq_len`=31 with depth 16 -> 16 writes.
- TIMEOUT_CYCLES=50, never complete entry 1 -> `seq_timeout` pulse after 50 idle cycles, `seq_busy`=0; late `i2c_rdata_valid` produces no `rd_valid`.
- Spurious `i2c_wr_data_success` in IDLE and a second `seq_start` mid-run -> both ignored; counts unchanged.
- Macro on, REPEAT_GAP_CYCLES=10, `seq_repeat`=1 -> second identical command burst starts 10 cycles after first `seq_done`; `seq_repeat`=0 during gap -> IDLE after gap.
